// File: rtl/mcu_pkg.sv
// mcu_pkg
//   Shared definitions for the multicycle MIPS control unit: the FSM state
//   type, opcode/funct field values, ULA operation codes, datapath select
//   encodings, the per-state control word and the state-to-control decode.
package mcu_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_BEQ      = 4'd8,
    S_ADDI_EX  = 4'd9,
    S_ADDI_WB  = 4'd10,
    S_JUMP     = 4'd11,
    S_JR       = 4'd12,
    S_JAL      = 4'd13
  } state_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_JR  = 6'b001000;

  // ULA operation codes
  localparam logic [2:0] ULA_ADD = 3'b010;
  localparam logic [2:0] ULA_SUB = 3'b110;
  localparam logic [2:0] ULA_AND = 3'b000;
  localparam logic [2:0] ULA_OR  = 3'b001;
  localparam logic [2:0] ULA_NOR = 3'b011;
  localparam logic [2:0] ULA_SLT = 3'b111;

  // Datapath select encodings
  localparam logic       IORD_PC         = 1'b0;
  localparam logic       IORD_ULAOUT     = 1'b1;
  localparam logic [1:0] REGDST_RT       = 2'b00;
  localparam logic [1:0] REGDST_RD       = 2'b01;
  localparam logic [1:0] REGDST_RA       = 2'b10;
  localparam logic [1:0] MEMTOREG_ULAOUT = 2'b00;
  localparam logic [1:0] MEMTOREG_MDR    = 2'b01;
  localparam logic [1:0] MEMTOREG_PC     = 2'b10;
  localparam logic       SRCA_PC         = 1'b0;
  localparam logic       SRCA_A          = 1'b1;
  localparam logic [1:0] SRCB_B          = 2'b00;
  localparam logic [1:0] SRCB_FOUR       = 2'b01;
  localparam logic [1:0] SRCB_IMM        = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2    = 2'b11;
  localparam logic [1:0] PCSRC_ULARESULT = 2'b00;
  localparam logic [1:0] PCSRC_ULAOUT    = 2'b01;
  localparam logic [1:0] PCSRC_JUMP      = 2'b10;
  localparam logic [1:0] PCSRC_A         = 2'b11;

  typedef struct packed {
    logic       pcWrite;
    logic       branch;
    logic       iorD;
    logic       memWrite;
    logic       irWrite;
    logic [1:0] regDst;
    logic [1:0] memtoReg;
    logic       regWrite;
    logic       ulaSrcA;
    logic [1:0] ulaSrcB;
    logic [2:0] ulaControl;
    logic [1:0] pcSrc;
    logic       done;
  } ctrl_t;

  // Control word driven while the FSM sits in state s. Everything not set
  // explicitly stays 0, so enables are inactive in any state not listed.
  function automatic ctrl_t ctrlFor(state_t s, logic [2:0] rtypeUla);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.iorD       = IORD_PC;
        c.irWrite    = 1'b1;
        c.ulaSrcA    = SRCA_PC;
        c.ulaSrcB    = SRCB_FOUR;
        c.ulaControl = ULA_ADD;
        c.pcSrc      = PCSRC_ULARESULT;
        c.pcWrite    = 1'b1;
      end
      S_DECODE: begin
        c.ulaSrcA    = SRCA_PC;
        c.ulaSrcB    = SRCB_IMM_SH2;
        c.ulaControl = ULA_ADD;
      end
      S_MEMADR, S_ADDI_EX: begin
        c.ulaSrcA    = SRCA_A;
        c.ulaSrcB    = SRCB_IMM;
        c.ulaControl = ULA_ADD;
      end
      S_MEMRD: c.iorD = IORD_ULAOUT;
      S_MEMWB: begin
        c.regDst   = REGDST_RT;
        c.memtoReg = MEMTOREG_MDR;
        c.regWrite = 1'b1;
        c.done     = 1'b1;
      end
      S_MEMWR: begin
        c.iorD     = IORD_ULAOUT;
        c.memWrite = 1'b1;
        c.done     = 1'b1;
      end
      S_RTYPE_EX: begin
        c.ulaSrcA    = SRCA_A;
        c.ulaSrcB    = SRCB_B;
        c.ulaControl = rtypeUla;
      end
      S_RTYPE_WB: begin
        c.regDst   = REGDST_RD;
        c.memtoReg = MEMTOREG_ULAOUT;
        c.regWrite = 1'b1;
        c.done     = 1'b1;
      end
      S_BEQ: begin
        c.ulaSrcA    = SRCA_A;
        c.ulaSrcB    = SRCB_B;
        c.ulaControl = ULA_SUB;
        c.pcSrc      = PCSRC_ULAOUT;
        c.branch     = 1'b1;
        c.done       = 1'b1;
      end
      S_ADDI_WB: begin
        c.regDst   = REGDST_RT;
        c.memtoReg = MEMTOREG_ULAOUT;
        c.regWrite = 1'b1;
        c.done     = 1'b1;
      end
      S_JUMP: begin
        c.pcSrc   = PCSRC_JUMP;
        c.pcWrite = 1'b1;
        c.done    = 1'b1;
      end
      S_JR: begin
        c.pcSrc   = PCSRC_A;
        c.pcWrite = 1'b1;
        c.done    = 1'b1;
      end
      // PC has not been redirected yet, so MemtoReg=PC writes PC+4 to $ra.
      S_JAL: begin
        c.pcSrc    = PCSRC_JUMP;
        c.pcWrite  = 1'b1;
        c.regWrite = 1'b1;
        c.regDst   = REGDST_RA;
        c.memtoReg = MEMTOREG_PC;
        c.done     = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ula_decoder.sv
// ula_decoder
//   Combinational R-type funct to ULA operation decode.
//   funct_i      in  WIDTH  IR[5:0]
//   ulaControl_o out 3      ULA operation; unknown funct falls back to add
module ula_decoder
  import mcu_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] funct_i,
  output logic [2:0]       ulaControl_o
);

  // Unknown funct values still execute (as add) so the write-back proceeds.
  always_comb begin
    ulaControl_o = ULA_ADD;
    case (funct_i)
      WIDTH'(FUNCT_ADD): ulaControl_o = ULA_ADD;
      WIDTH'(FUNCT_SUB): ulaControl_o = ULA_SUB;
      WIDTH'(FUNCT_AND): ulaControl_o = ULA_AND;
      WIDTH'(FUNCT_OR):  ulaControl_o = ULA_OR;
      WIDTH'(FUNCT_NOR): ulaControl_o = ULA_NOR;
      WIDTH'(FUNCT_SLT): ulaControl_o = ULA_SLT;
      default:           ulaControl_o = ULA_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
//   Moore FSM sequencing the shared-memory multicycle MIPS datapath.
//   Inputs : clk, rst_n (async active-low), OP, Funct, Zero.
//   Outputs: PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
//            ULASrcA, ULASrcB, ULAControl, PCSrc, instr_done, retired.
//   The control word is registered alongside the state (decoded from the
//   next state), so outputs change cleanly on the clock edge. Only PCEn
//   looks at a live input (Zero) to resolve beq in its own cycle.
module multicycle_control_unit
  import mcu_pkg::*;
#(
  parameter int WIDTH     = 6,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     OP,
  input  logic [WIDTH-1:0]     Funct,
  input  logic                 Zero,
  output logic                 PCEn,
  output logic                 IorD,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic [1:0]           RegDst,
  output logic [1:0]           MemtoReg,
  output logic                 RegWrite,
  output logic                 ULASrcA,
  output logic [1:0]           ULASrcB,
  output logic [2:0]           ULAControl,
  output logic [1:0]           PCSrc,
  output logic                 instr_done,
  output logic [CNT_WIDTH-1:0] retired
);

  state_t               state_q;
  state_t               state_d;
  ctrl_t                ctrl_q;
  logic [CNT_WIDTH-1:0] retired_q;
  logic [2:0]           rtypeUla;
  logic                 stateValid;
  logic                 writeOk;

  ula_decoder #(.WIDTH(WIDTH)) uUlaDecoder (
    .funct_i      (Funct),
    .ulaControl_o (rtypeUla)
  );

  // Next-state selection. OP/Funct are stable from DECODE onwards, so the
  // RTYPE_EX ULA code decoded while leaving DECODE is still the right one.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (OP)
          WIDTH'(OP_LW), WIDTH'(OP_SW): state_d = S_MEMADR;
          WIDTH'(OP_RTYPE): state_d = (Funct == WIDTH'(FUNCT_JR)) ? S_JR : S_RTYPE_EX;
          WIDTH'(OP_BEQ):   state_d = S_BEQ;
          WIDTH'(OP_ADDI):  state_d = S_ADDI_EX;
          WIDTH'(OP_J):     state_d = S_JUMP;
          WIDTH'(OP_JAL):   state_d = S_JAL;
          default:          state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (OP == WIDTH'(OP_LW)) ? S_MEMRD : S_MEMWR;
      S_MEMRD:    state_d = S_MEMWB;
      S_RTYPE_EX: state_d = S_RTYPE_WB;
      S_ADDI_EX:  state_d = S_ADDI_WB;
      default:    state_d = S_FETCH;
    endcase
  end

  // Corrupted state encodings must not fire any write while recovering.
  assign stateValid = (state_q <= S_JAL);

  // State, registered control word and retire counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      ctrl_q    <= ctrlFor(S_FETCH, ULA_ADD);
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrlFor(state_d, rtypeUla);
      retired_q <= retired_q + CNT_WIDTH'(stateValid & ctrl_q.done);
    end
  end

  // Enables are held off combinationally during reset so an abort takes
  // effect immediately, not on the next edge.
  assign writeOk    = rst_n & stateValid;
  assign PCEn       = writeOk & (ctrl_q.pcWrite | (ctrl_q.branch & Zero));
  assign IorD       = ctrl_q.iorD;
  assign MemWrite   = writeOk & ctrl_q.memWrite;
  assign IRWrite    = writeOk & ctrl_q.irWrite;
  assign RegDst     = ctrl_q.regDst;
  assign MemtoReg   = ctrl_q.memtoReg;
  assign RegWrite   = writeOk & ctrl_q.regWrite;
  assign ULASrcA    = ctrl_q.ulaSrcA;
  assign ULASrcB    = ctrl_q.ulaSrcB;
  assign ULAControl = ctrl_q.ulaControl;
  assign PCSrc      = ctrl_q.pcSrc;
  assign instr_done = writeOk & ctrl_q.done;
  assign retired    = retired_q;

endmodule
